// File: rtl/tweak_pkg.sv
// Shared definitions for the tweak register file.
//   state_e : sweep sequencer states (IDLE = 0, CLEAR = 1)
//   clog2   : address width helper, never returns less than 1
package tweak_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/tweak_regfile_mp_if.sv
// Write/read port bundle of the multi-port register file.
//   wr_en/wr_addr/wr_data : single write port
//   rd_en/rd_addr         : NREAD read strobes and packed addresses
//   rd_data/rd_valid      : packed registered read data, per-port valid pulse
// The address width is derived from DEPTH and cannot be overridden.
interface tweak_regfile_mp_if
   import tweak_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int NREAD = 2
) ();

   localparam int AW = clog2(DEPTH);

   logic                   wr_en;
   logic [AW-1:0]          wr_addr;
   logic [WIDTH-1:0]       wr_data;
   logic [NREAD-1:0]       rd_en;
   logic [NREAD*AW-1:0]    rd_addr;
   logic [NREAD*WIDTH-1:0] rd_data;
   logic [NREAD-1:0]       rd_valid;

   modport master (
      output wr_en, wr_addr, wr_data, rd_en, rd_addr,
      input  rd_data, rd_valid
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
      output rd_data, rd_valid
   );

endinterface

// File: rtl/tweak_clear_seq.sv
// Clear sweep sequencer: owns the IDLE/CLEAR FSM and sweep counter.
//   CLK, NRES  : clock, synchronous active-low reset (forces a fresh sweep)
//   clr        : start a sweep from IDLE
//   busy       : high while sweeping (exactly DEPTH cycles)
//   sweep_we   : zero-write strobe into the array
//   sweep_addr : register being zeroed this cycle
//
// state | meaning
// IDLE  | normal port access
// CLEAR | zeroing register[cnt] each cycle, ports ignored
module tweak_clear_seq
   import tweak_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int AW   = clog2(DEPTH)
) (
   input  logic          CLK,
   input  logic          NRES,
   input  logic          clr,
   output logic          busy,
   output logic          sweep_we,
   output logic [AW-1:0] sweep_addr
);

   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   state_e        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (clr) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) state_d = IDLE;
         end
         default: state_d = CLEAR;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!NRES) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy       = (state_q == CLEAR);
   assign sweep_we   = (state_q == CLEAR);
   assign sweep_addr = cnt_q;

endmodule

// File: rtl/tweak_regfile_mp.sv
// Multi-port register file with write-first bypass and a self-clearing sweep.
//   CLK, NRES : clock, synchronous active-low reset (triggers a full sweep)
//   clr       : request a sweep zeroing every register
//   busy      : sweep in progress; port accesses are ignored meanwhile
//   bus       : slave side of tweak_regfile_mp_if (1 write, NREAD read ports)
module tweak_regfile_mp
   import tweak_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 16,
   parameter int NREAD   = 2,
   parameter int ZERO_R0 = 0
) (
   input  logic             CLK,
   input  logic             NRES,
   input  logic             clr,
   output logic             busy,
   tweak_regfile_mp_if.slave bus
);

   localparam int AW  = clog2(DEPTH);
   localparam bit FULL = (DEPTH == (1 << AW));

   logic [WIDTH-1:0]       mem_q [DEPTH];
   logic                   mem_we;
   logic [AW-1:0]          mem_wa;
   logic [WIDTH-1:0]       mem_wd;
   logic                   sweep_we;
   logic [AW-1:0]          sweep_addr;
   logic [NREAD*WIDTH-1:0] rd_data_q, rd_data_d;
   logic [NREAD-1:0]       rd_valid_q, rd_valid_d;
   logic [AW-1:0]          ra;

   tweak_clear_seq #(.DEPTH(DEPTH)) u_seq (
      .CLK        (CLK),
      .NRES       (NRES),
      .clr        (clr),
      .busy       (busy),
      .sweep_we   (sweep_we),
      .sweep_addr (sweep_addr)
   );

   function automatic logic addr_ok(input logic [AW-1:0] a);
      return FULL || ({{(32-AW){1'b0}}, a} < 32'(DEPTH));
   endfunction

   // Register 0 reads as zero and is never stored when hardwired.
   function automatic logic is_zero_reg(input logic [AW-1:0] a);
      return (ZERO_R0 != 0) && (a == '0);
   endfunction

   // Single write mux: the sweep wins over the port.
   always_comb begin
      mem_we = 1'b0;
      mem_wa = bus.wr_addr;
      mem_wd = bus.wr_data;
      if (sweep_we) begin
         mem_we = 1'b1;
         mem_wa = sweep_addr;
         mem_wd = '0;
      end else if (NRES && bus.wr_en && addr_ok(bus.wr_addr) && !is_zero_reg(bus.wr_addr)) begin
         mem_we = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (mem_we) mem_q[mem_wa] <= mem_wd;
   end

   always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = '0;
      ra         = '0;
      if (!busy) begin
         for (int p = 0; p < NREAD; p++) begin
            if (bus.rd_en[p]) begin
               ra            = bus.rd_addr[p*AW +: AW];
               rd_valid_d[p] = 1'b1;
               if (!addr_ok(ra) || is_zero_reg(ra))
                  rd_data_d[p*WIDTH +: WIDTH] = '0;
               else if (bus.wr_en && (bus.wr_addr == ra))
                  rd_data_d[p*WIDTH +: WIDTH] = bus.wr_data;
               else
                  rd_data_d[p*WIDTH +: WIDTH] = mem_q[ra];
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!NRES) begin
         rd_data_q  <= '0;
         rd_valid_q <= '0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;

endmodule

// File: doc/tweak_regfile_mp.md
TWEAK_REGFILE_MP -- requirements
Module: tweak_regfile_mp

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, number of registers (2..256, any integer).
REQ-003 The block SHALL have parameter NREAD, default 2, number of independent read ports (1..4).
REQ-004 The block SHALL have parameter ZERO_R0, default 0; when 1, register 0 is hardwired to zero.
REQ-005 AW SHALL be derived as ceil(log2(DEPTH)), minimum 1, and SHALL NOT be user-overridable.
REQ-006 The block SHALL have port CLK, input, 1, the single clock; all state updates on posedge.
REQ-007 The block SHALL have port NRES, input, 1, synchronous active-low reset.
REQ-008 The block SHALL have port clr, input, 1, request to zero the whole register array.
REQ-009 The block SHALL have port busy, output, 1, high while a clear sweep is in progress.
REQ-010 The block SHALL have port wr_en, input, 1, write strobe.
REQ-011 The block SHALL have port wr_addr, input, AW, write address.
REQ-012 The block SHALL have port wr_data, input, WIDTH, write data.
REQ-013 The block SHALL have port rd_en, input, NREAD, one read strobe per port.
REQ-014 The block SHALL have port rd_addr, input, NREAD*AW, packed read addresses; port p uses bits [p*AW +: AW].
REQ-015 The block SHALL have port rd_data, output, NREAD*WIDTH, packed registered read data; port p uses bits [p*WIDTH +: WIDTH].
REQ-016 The block SHALL have port rd_valid, output, NREAD, per-port one-cycle read-complete pulse.

Function
REQ-017 The block SHALL have two states, IDLE and CLEAR, and a sweep counter of width AW.
REQ-018 In IDLE, with wr_en=1 at a posedge, the block SHALL write wr_data to wr_addr at that edge.
REQ-019 In IDLE, with rd_en[p]=1 at a posedge, rd_data[p] SHALL hold the register contents after that edge, and rd_valid[p] SHALL be 1 for exactly that following cycle (latency 1).
REQ-020 When rd_en[p]=0, rd_data[p] SHALL hold its previous value and rd_valid[p] SHALL be 0.
REQ-021 A read and a write to the same address at the same edge SHALL return wr_data (write-first bypass), independently on every port.
REQ-022 Two or more ports reading the same address at the same edge SHALL all return the same value.
REQ-023 With ZERO_R0=1, writes to address 0 SHALL be discarded, reads of address 0 SHALL return 0, and the bypass SHALL NOT apply to address 0.
REQ-024 Addresses >= DEPTH SHALL be handled as follows: writes discarded; reads return 0 with rd_valid still pulsed.
REQ-025 IDLE->CLEAR: clr=1 at a posedge in IDLE; the counter SHALL be loaded with 0 and busy SHALL be 1 from the next cycle.
REQ-026 In CLEAR, the block SHALL write register[counter] to 0 each cycle and increment the counter; after writing DEPTH-1 it SHALL return to IDLE, so busy is high for exactly DEPTH cycles.
REQ-027 In CLEAR, wr_en, rd_en and clr SHALL be ignored: no array write from the port, rd_valid=0, rd_data held, no sweep restart.
REQ-028 clr and wr_en both high in IDLE at the same edge: the write SHALL complete at that edge and the sweep SHALL then zero it.

Reset
REQ-029 When NRES=0 at a posedge, the block SHALL set rd_data=0, rd_valid=0, state=CLEAR, counter=0, and busy=1 from the next cycle.
REQ-030 On release of NRES, a full DEPTH-cycle sweep SHALL run; array contents are defined only after busy falls.
REQ-031 NRES=0 during a sweep SHALL restart the sweep from counter 0.

Structure
REQ-032 The shared package tweak_pkg SHALL hold the state encoding (IDLE=0, CLEAR=1) and a clog2 constant function.
REQ-033 A sub-module tweak_clear_seq SHALL own the FSM, sweep counter, and busy signal, and SHALL output the sweep write enable and address to the array.
REQ-034 The array SHALL be a single behavioural memory with one write mux, sweep having priority over port writes.

Verification
REQ-035 The bench SHALL cover reset: NRES low 2 cycles, release -> busy high for exactly 16 cycles (defaults), then any read returns 0.
REQ-036 The bench SHALL cover write/read: write 0xDEADBEEF to r5, next cycle rd_en[0] r5 -> rd_data[0]=0xDEADBEEF with rd_valid[0]=1 one cycle later.
REQ-037 The bench SHALL cover bypass: same edge write 0x12345678 to r3 while both ports read r3 -> both return 0x12345678.
REQ-038 The bench SHALL cover clear: fill r0..r15 with index+1, pulse clr -> busy 16 cycles, reads attempted during sweep give rd_valid=0, afterwards all reads return 0.
REQ-039 The bench SHALL cover ZERO_R0=1, DEPTH=12: write 0xFF to r0 and to address 13 -> reads of both return 0; r11 write/read round-trips.
REQ-040 The bench SHALL cover reset mid-sweep: NRES low at sweep cycle 7 -> after release, busy high for a full 16 cycles.
